rename_rf_ckpt: RTL and testbench

RENAME_RF_CKPT -- requirements
Module: rename_rf_ckpt

---
 rtl/rename_rf_ckpt_pkg.sv | 17 +
 rtl/rename_rf_ckpt_if.sv | 53 +++++
 rtl/rename_rf_ckpt_prio_enc.sv | 22 ++
 rtl/rename_rf_ckpt.sv | 178 +++++++++++++++++
 tb/tb_rename_rf_ckpt.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rename_rf_ckpt_pkg.sv
// Shared defaults and width helpers for the rename map / physical register file
// with branch checkpoints.
package rename_pkg;

  localparam int ARCH_REGS_DEF = 32;
  localparam int PHYS_REGS_DEF = 64;
  localparam int DATA_W_DEF    = 32;
  localparam int NUM_RD_DEF    = 2;
  localparam int NUM_WR_DEF    = 2;
  localparam int NUM_CKPT_DEF  = 4;

  // Index width for n entries, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rename_rf_ckpt_if.sv
// Pipeline-facing bundle of the rename block: rename, map/data reads,
// writeback, commit-free and checkpoint control.
interface rename_rf_ckpt_if
  import rename_pkg::*;
#(
  parameter int ARCH_REGS = ARCH_REGS_DEF,
  parameter int PHYS_REGS = PHYS_REGS_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NUM_RD    = NUM_RD_DEF,
  parameter int NUM_WR    = NUM_WR_DEF,
  parameter int NUM_CKPT  = NUM_CKPT_DEF
);
  localparam int AW = clog2_min1(ARCH_REGS);
  localparam int NW = clog2_min1(PHYS_REGS);
  localparam int CW = clog2_min1(NUM_CKPT);

  // Handshakes: a rename (ALLOC_E) or checkpoint (CKPT_E) request takes effect
  // only in a cycle where its READY is high; otherwise it is dropped, not held.
  logic [AW-1:0]          ALLOC_ADDR;
  logic                   ALLOC_E;
  logic [NW-1:0]          ALLOC_NAME;
  logic                   ALLOC_READY;
  logic [NUM_RD*AW-1:0]   RD_ADDR;
  logic [NUM_RD*NW-1:0]   RD_NAME;
  logic [NUM_RD*NW-1:0]   RD_PNAME;
  logic [NUM_RD*DATA_W-1:0] RD_DATA;
  logic [NUM_RD-1:0]      RD_VALID;
  logic [NUM_WR*NW-1:0]   WR_NAME;
  logic [NUM_WR*DATA_W-1:0] WR_DATA;
  logic [NUM_WR-1:0]      WR_E;
  logic [NW-1:0]          FREE_NAME;
  logic                   FREE_E;
  logic                   CKPT_E;
  logic [CW-1:0]          CKPT_ID;
  logic                   CKPT_READY;
  logic                   REL_E;
  logic [CW-1:0]          REL_ID;
  logic                   RB_E;
  logic [CW-1:0]          RB_ID;

  modport master (
    output ALLOC_ADDR, ALLOC_E, RD_ADDR, RD_PNAME, WR_NAME, WR_DATA, WR_E,
           FREE_NAME, FREE_E, CKPT_E, REL_E, REL_ID, RB_E, RB_ID,
    input  ALLOC_NAME, ALLOC_READY, RD_NAME, RD_DATA, RD_VALID, CKPT_ID, CKPT_READY
  );

  modport slave (
    input  ALLOC_ADDR, ALLOC_E, RD_ADDR, RD_PNAME, WR_NAME, WR_DATA, WR_E,
           FREE_NAME, FREE_E, CKPT_E, REL_E, REL_ID, RB_E, RB_ID,
    output ALLOC_NAME, ALLOC_READY, RD_NAME, RD_DATA, RD_VALID, CKPT_ID, CKPT_READY
  );

endinterface

// File: rtl/rename_rf_ckpt_prio_enc.sv
// Lowest-set-bit encoder with an any-bit-set flag.
module prio_enc
  import rename_pkg::*;
#(
  parameter int N = 8,
  localparam int W = clog2_min1(N)
) (
  input  logic [N-1:0] in_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_i[i]) idx_o = W'(i);
    end
  end

  assign valid_o = |in_i;

endmodule

// File: rtl/rename_rf_ckpt.sv
// Register rename map, free/busy tracking and physical data file, with map
// checkpoints that can be retired or rolled back on a mispredict.
module rename_rf_ckpt
  import rename_pkg::*;
#(
  parameter int ARCH_REGS = ARCH_REGS_DEF,
  parameter int PHYS_REGS = PHYS_REGS_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NUM_RD    = NUM_RD_DEF,
  parameter int NUM_WR    = NUM_WR_DEF,
  parameter int NUM_CKPT  = NUM_CKPT_DEF
) (
  input logic            CLK,
  input logic            RST,
  rename_rf_ckpt_if.slave io
);
  localparam int AW = clog2_min1(ARCH_REGS);
  localparam int NW = clog2_min1(PHYS_REGS);
  localparam int CW = clog2_min1(NUM_CKPT);

  if (PHYS_REGS <= ARCH_REGS) begin : g_param_check
    $error("rename_rf_ckpt: PHYS_REGS must exceed ARCH_REGS");
  end

  typedef logic [NW-1:0]        name_t;
  typedef logic [PHYS_REGS-1:0] pmask_t;
  typedef logic [NUM_CKPT-1:0]  cmask_t;

  name_t             map_q   [ARCH_REGS];
  name_t             map_d   [ARCH_REGS];
  name_t             old_q   [PHYS_REGS];
  name_t             old_d   [PHYS_REGS];
  pmask_t            free_q, free_d;
  pmask_t            busy_q, busy_d;
  logic [DATA_W-1:0] data_q  [PHYS_REGS];
  cmask_t            live_q, live_d;
  // older_q[s][j]: slot j was live (hence older) when slot s was taken.
  cmask_t            older_q [NUM_CKPT];
  cmask_t            older_d [NUM_CKPT];
  pmask_t            amask_q [NUM_CKPT];
  pmask_t            amask_d [NUM_CKPT];
  name_t             snap_q  [NUM_CKPT][ARCH_REGS];
  name_t             snap_d  [NUM_CKPT][ARCH_REGS];

  name_t           alloc_name;
  logic            alloc_ready;
  logic [CW-1:0]   ckpt_id;
  logic            ckpt_ready;

  prio_enc #(.N(PHYS_REGS)) u_free_enc (
    .in_i    (free_q),
    .idx_o   (alloc_name),
    .valid_o (alloc_ready)
  );

  prio_enc #(.N(NUM_CKPT)) u_ckpt_enc (
    .in_i    (~live_q),
    .idx_o   (ckpt_id),
    .valid_o (ckpt_ready)
  );

  logic   rb_go, alloc_go, ckpt_go, rel_go;
  cmask_t rb_kill;

  // A rollback on a live slot blocks the speculative-path requests of its cycle.
  assign rb_go    = io.RB_E && live_q[io.RB_ID];
  assign alloc_go = io.ALLOC_E && alloc_ready && !rb_go;
  assign ckpt_go  = io.CKPT_E && ckpt_ready && !rb_go;
  assign rel_go   = io.REL_E && live_q[io.REL_ID] && !rb_go;

  always_comb begin
    rb_kill = '0;
    for (int c = 0; c < NUM_CKPT; c++) begin
      rb_kill[c] = live_q[c] & older_q[c][io.RB_ID];
    end
    rb_kill[io.RB_ID] = 1'b1;
  end

  always_comb begin
    map_d   = map_q;
    old_d   = old_q;
    free_d  = free_q;
    busy_d  = busy_q;
    live_d  = live_q;
    older_d = older_q;
    amask_d = amask_q;
    snap_d  = snap_q;

    if (alloc_go) begin
      map_d[io.ALLOC_ADDR] = alloc_name;
      old_d[alloc_name]    = map_q[io.ALLOC_ADDR];
      free_d[alloc_name]   = 1'b0;
      busy_d[alloc_name]   = 1'b1;
      for (int c = 0; c < NUM_CKPT; c++) begin
        if (live_q[c]) amask_d[c][alloc_name] = 1'b1;
      end
    end

    // The snapshot already contains this cycle's rename, so its mask starts empty.
    if (ckpt_go) begin
      snap_d[ckpt_id]  = map_d;
      amask_d[ckpt_id] = '0;
      live_d[ckpt_id]  = 1'b1;
      for (int c = 0; c < NUM_CKPT; c++) begin
        older_d[c][ckpt_id] = 1'b0;
      end
      older_d[ckpt_id] = live_q;
    end

    if (rel_go) live_d[io.REL_ID] = 1'b0;

    if (rb_go) begin
      map_d  = snap_q[io.RB_ID];
      free_d = free_d | amask_q[io.RB_ID];
      busy_d = busy_d & ~amask_q[io.RB_ID];
      live_d = live_q & ~rb_kill;
    end

    if (io.FREE_E) free_d[old_q[io.FREE_NAME]] = 1'b1;

    for (int k = 0; k < NUM_WR; k++) begin
      if (io.WR_E[k]) busy_d[io.WR_NAME[k*NW +: NW]] = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= name_t'(i);
      for (int i = 0; i < PHYS_REGS; i++) begin
        old_q[i]  <= '0;
        free_q[i] <= (i >= ARCH_REGS);
      end
      busy_q <= '0;
      live_q <= '0;
      for (int c = 0; c < NUM_CKPT; c++) begin
        older_q[c] <= '0;
        amask_q[c] <= '0;
      end
    end else begin
      map_q   <= map_d;
      old_q   <= old_d;
      free_q  <= free_d;
      busy_q  <= busy_d;
      live_q  <= live_d;
      older_q <= older_d;
      amask_q <= amask_d;
    end
  end

  // Snapshot contents are only meaningful while their slot is live.
  always_ff @(posedge CLK) begin
    snap_q <= snap_d;
  end

  // Later ports override earlier ones on a shared name.
  always_ff @(posedge CLK) begin
    for (int k = 0; k < NUM_WR; k++) begin
      if (io.WR_E[k]) data_q[io.WR_NAME[k*NW +: NW]] <= io.WR_DATA[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    io.RD_NAME  = '0;
    io.RD_DATA  = '0;
    io.RD_VALID = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      io.RD_NAME[r*NW +: NW]         = map_q[io.RD_ADDR[r*AW +: AW]];
      io.RD_DATA[r*DATA_W +: DATA_W] = data_q[io.RD_PNAME[r*NW +: NW]];
      io.RD_VALID[r]                 = ~busy_q[io.RD_PNAME[r*NW +: NW]];
    end
  end

  assign io.ALLOC_NAME  = alloc_name;
  assign io.ALLOC_READY = alloc_ready;
  assign io.CKPT_ID     = ckpt_id;
  assign io.CKPT_READY  = ckpt_ready;

endmodule

// File: tb/tb_rename_rf_ckpt.sv
// Directed bench for rename_rf_ckpt with 4 architectural / 8 physical registers
// and 2 checkpoint slots.
`timescale 1ns/1ps
module tb_rename_rf_ckpt;
  localparam int ARCH_REGS = 4;
  localparam int PHYS_REGS = 8;
  localparam int DATA_W    = 32;
  localparam int NUM_RD    = 2;
  localparam int NUM_WR    = 2;
  localparam int NUM_CKPT  = 2;

  logic CLK;
  logic RST;
  int   n_asserts = 0;
  int   n_fail    = 0;
  logic [DATA_W-1:0] exp_q[$];

  rename_rf_ckpt_if #(
    .ARCH_REGS(ARCH_REGS), .PHYS_REGS(PHYS_REGS), .DATA_W(DATA_W),
    .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .NUM_CKPT(NUM_CKPT)
  ) bus ();

  rename_rf_ckpt #(
    .ARCH_REGS(ARCH_REGS), .PHYS_REGS(PHYS_REGS), .DATA_W(DATA_W),
    .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .NUM_CKPT(NUM_CKPT)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .io  (bus)
  );

  // Clock and watchdog
  initial begin
    CLK = 1'b0;
    forever #50 CLK = ~CLK;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.ALLOC_ADDR = '0; bus.ALLOC_E = 1'b0;
    bus.RD_ADDR    = '0; bus.RD_PNAME = '0;
    bus.WR_NAME    = '0; bus.WR_DATA  = '0; bus.WR_E = '0;
    bus.FREE_NAME  = '0; bus.FREE_E   = 1'b0;
    bus.CKPT_E     = 1'b0;
    bus.REL_E      = 1'b0; bus.REL_ID = '0;
    bus.RB_E       = 1'b0; bus.RB_ID  = '0;
  endtask

  task automatic do_reset();
    idle();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic alloc(input int a);
    bus.ALLOC_ADDR = a[1:0];
    bus.ALLOC_E = 1'b1;
    tick();
    bus.ALLOC_E = 1'b0;
  endtask

  task automatic ckpt();
    bus.CKPT_E = 1'b1;
    tick();
    bus.CKPT_E = 1'b0;
  endtask

  // Checks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_map(input string tag, input int a, input int e);
    bus.RD_ADDR = {a[1:0], a[1:0]};
    #1;
    chk(tag, 32'(bus.RD_NAME[2:0]), e);
  endtask

  task automatic chk_valid(input string tag, input int n, input int e);
    bus.RD_PNAME = {n[2:0], n[2:0]};
    #1;
    chk(tag, 32'(bus.RD_VALID[1]), e);
  endtask

  task automatic chk_data(input string tag, input int n, input logic [31:0] e);
    bus.RD_PNAME = {n[2:0], n[2:0]};
    #1;
    chk(tag, bus.RD_DATA[31:0], e);
  endtask

  initial begin
    do_reset();
    tick();

    // Reset state
    chk("rst_alloc_ready", 32'(bus.ALLOC_READY), 1);
    chk("rst_alloc_name", 32'(bus.ALLOC_NAME), 4);
    chk("rst_ckpt_ready", 32'(bus.CKPT_READY), 1);
    chk("rst_ckpt_id", 32'(bus.CKPT_ID), 0);
    chk_map("rst_map2", 2, 2);
    chk_map("rst_map3", 3, 3);
    chk_valid("rst_valid0", 0, 1);
    chk_valid("rst_valid7", 7, 1);

    // Rename, then writeback visible one cycle later
    alloc(1);
    chk_map("alloc_map1", 1, 4);
    chk_valid("alloc_busy4", 4, 0);
    chk("alloc_next_name", 32'(bus.ALLOC_NAME), 5);
    bus.WR_NAME = {3'd0, 3'd4};
    bus.WR_DATA = {32'd0, 32'hAB};
    bus.WR_E = 2'b01;
    exp_q.push_back(32'hAB);
    chk_valid("wr_no_bypass", 4, 0);
    tick();
    bus.WR_E = '0;
    chk_data("wr_data4", 4, exp_q.pop_front());
    chk_valid("wr_valid4", 4, 1);

    // Exhaust the free list, then release the displaced name
    alloc(2);
    alloc(3);
    alloc(0);
    chk("full_alloc_ready", 32'(bus.ALLOC_READY), 0);
    chk_map("full_map0", 0, 7);
    alloc(1);
    chk_map("full_ignored_map1", 1, 4);
    bus.FREE_NAME = 3'd4;
    bus.FREE_E = 1'b1;
    tick();
    bus.FREE_E = 1'b0;
    chk("free_alloc_name", 32'(bus.ALLOC_NAME), 1);
    chk("free_alloc_ready", 32'(bus.ALLOC_READY), 1);

    // Single checkpoint rollback
    do_reset();
    bus.CKPT_E = 1'b1;
    #1;
    chk("ckpt_id_first", 32'(bus.CKPT_ID), 0);
    tick();
    bus.CKPT_E = 1'b0;
    chk("ckpt_id_next", 32'(bus.CKPT_ID), 1);
    chk("ckpt_ready_one", 32'(bus.CKPT_READY), 1);
    alloc(2);
    alloc(3);
    chk_map("pre_rb_map3", 3, 5);
    chk_valid("pre_rb_busy5", 5, 0);
    bus.RB_E = 1'b1; bus.RB_ID = 1'b0;
    tick();
    bus.RB_E = 1'b0;
    chk_map("rb_map2", 2, 2);
    chk_map("rb_map3", 3, 3);
    chk("rb_alloc_name", 32'(bus.ALLOC_NAME), 4);
    chk_valid("rb_valid4", 4, 1);
    chk_valid("rb_valid5", 5, 1);
    chk("rb_ckpt_ready", 32'(bus.CKPT_READY), 1);
    chk("rb_ckpt_id", 32'(bus.CKPT_ID), 0);
    alloc(0);
    chk("rb_name5_free", 32'(bus.ALLOC_NAME), 5);
    chk_map("rb_realloc_map0", 0, 4);

    // Nested checkpoints, rollback to the older one
    do_reset();
    ckpt();
    alloc(1);
    ckpt();
    chk("nest_ckpt_full", 32'(bus.CKPT_READY), 0);
    alloc(2);
    bus.RB_E = 1'b1; bus.RB_ID = 1'b0;
    tick();
    bus.RB_E = 1'b0;
    chk_map("nest_map1", 1, 1);
    chk_map("nest_map2", 2, 2);
    chk("nest_ckpt_ready", 32'(bus.CKPT_READY), 1);
    chk("nest_ckpt_id", 32'(bus.CKPT_ID), 0);
    chk("nest_alloc_name", 32'(bus.ALLOC_NAME), 4);
    bus.REL_E = 1'b1; bus.REL_ID = 1'b1;
    tick();
    bus.REL_E = 1'b0;
    chk("rel_dead_ckpt_id", 32'(bus.CKPT_ID), 0);

    // Effective rollback suppresses a same-cycle rename
    ckpt();
    bus.RB_E = 1'b1; bus.RB_ID = 1'b0;
    bus.ALLOC_E = 1'b1; bus.ALLOC_ADDR = 2'd3;
    bus.REL_E = 1'b1; bus.REL_ID = 1'b1;
    tick();
    idle();
    chk_map("rb_blocks_alloc", 3, 3);
    chk("rb_blocks_name", 32'(bus.ALLOC_NAME), 4);
    chk("rb_blocks_ckpt", 32'(bus.CKPT_ID), 0);

    // Rollback on a dead slot is ignored and blocks nothing
    bus.RB_E = 1'b1; bus.RB_ID = 1'b1;
    alloc(3);
    bus.RB_E = 1'b0;
    chk_map("dead_rb_map3", 3, 4);
    chk("dead_rb_name", 32'(bus.ALLOC_NAME), 5);

    // Reused slot 0 is younger than slot 1; rolling back slot 1 frees both
    ckpt();
    ckpt();
    bus.REL_E = 1'b1; bus.REL_ID = 1'b0;
    tick();
    bus.REL_E = 1'b0;
    chk("rel_frees_slot0", 32'(bus.CKPT_ID), 0);
    ckpt();
    chk("age_both_live", 32'(bus.CKPT_READY), 0);
    bus.RB_E = 1'b1; bus.RB_ID = 1'b1;
    tick();
    bus.RB_E = 1'b0;
    chk("age_rb_ckpt_id", 32'(bus.CKPT_ID), 0);
    chk("age_rb_ckpt_ready", 32'(bus.CKPT_READY), 1);
    chk_map("age_rb_map3", 3, 4);

    // Release and rollback of the same slot: rollback wins
    ckpt();
    alloc(0);
    chk_map("relrb_pre_map0", 0, 5);
    bus.REL_E = 1'b1; bus.REL_ID = 1'b0;
    bus.RB_E = 1'b1; bus.RB_ID = 1'b0;
    tick();
    idle();
    chk_map("relrb_map0", 0, 0);
    chk("relrb_name", 32'(bus.ALLOC_NAME), 5);

    // Two writers on one name: the higher port wins
    bus.WR_NAME = {3'd5, 3'd5};
    bus.WR_DATA = {32'd2, 32'd1};
    bus.WR_E = 2'b11;
    exp_q.push_back(32'd2);
    tick();
    bus.WR_E = '0;
    chk_data("wr_port_prio", 5, exp_q.pop_front());

    // Reset with live checkpoints
    ckpt();
    ckpt();
    alloc(1);
    chk("pre_rst_ckpt_full", 32'(bus.CKPT_READY), 0);
    chk_map("pre_rst_map1", 1, 5);
    do_reset();
    chk_map("rst2_map1", 1, 1);
    chk_map("rst2_map3", 3, 3);
    chk("rst2_ckpt_id", 32'(bus.CKPT_ID), 0);
    chk("rst2_ckpt_ready", 32'(bus.CKPT_READY), 1);
    chk("rst2_alloc_name", 32'(bus.ALLOC_NAME), 4);
    chk_valid("rst2_valid5", 5, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
